// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target block.
package i2c_pkg;

  localparam int I2C_ADDR_WIDTH = 7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    RX_DATA   = 3'd3,
    RX_ACK    = 3'd4,
    TX_DATA   = 3'd5,
    TX_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_slave_state_t;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one asynchronous bus line: 2-FF synchroniser, optional glitch
// filter (I2C_SLAVE_GLITCH_FILTER_EN) and rise/fall detection.
module i2c_line_cond #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic a_rst_n_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Bus lines idle high, so every stage resets to 1.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], line_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [CW-1:0] cnt_q;
  logic          filt_q;

  // The filtered level follows only after FILTER_LEN differing samples in a row.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else if (sync_q[1] == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
      cnt_q  <= '0;
      filt_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign level_o = filt_q;
`else
  logic unused_filter_len;
  assign unused_filter_len = |FILTER_LEN;
  assign level_o = sync_q[1];
`endif

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level_o;
    end
  end

  assign rise_o = level_o & ~prev_q;
  assign fall_o = ~level_o & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, byte receive to fabric and byte transmit
// from fabric. Optional input glitch filter via I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FILTER_LEN = 3
) (
  input  logic                      clk_i,
  input  logic                      a_rst_n_i,
  input  logic                      en_i,
  input  logic [I2C_ADDR_WIDTH-1:0] own_addr_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_o,
  output logic [DATA_WIDTH-1:0]     rx_data_o,
  output logic                      rx_valid_o,
  input  logic [DATA_WIDTH-1:0]     tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic                      dir_o,
  output logic                      start_o,
  output logic                      stop_o,
  output logic                      busy_o
);

  localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] BYTE_DONE = 4'(DATA_WIDTH);

  i2c_slave_state_t      state_q;
  logic [3:0]            bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  ack_drv_q;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;
  logic [DATA_WIDTH-1:0] tx_byte;

  i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_scl_cond (
    .clk_i     (clk_i),
    .a_rst_n_i (a_rst_n_i),
    .line_i    (scl_i),
    .level_o   (scl_lvl),
    .rise_o    (scl_rise),
    .fall_o    (scl_fall)
  );

  i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_sda_cond (
    .clk_i     (clk_i),
    .a_rst_n_i (a_rst_n_i),
    .line_i    (sda_i),
    .level_o   (sda_lvl),
    .rise_o    (sda_rise),
    .fall_o    (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  // An empty fabric side sends all-ones, which leaves the bus released.
  assign tx_byte   = tx_valid_i ? tx_data_i : '1;

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ack_drv_q  <= 1'b0;
      sda_o      <= 1'b1;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;
      dir_o      <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      rx_valid_o <= 1'b0;
      tx_ready_o <= 1'b0;

      if (start_det) begin
        start_o   <= 1'b1;
        busy_o    <= 1'b1;
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_o     <= 1'b1;
      end else if (stop_det) begin
        stop_o  <= 1'b1;
        busy_o  <= 1'b0;
        dir_o   <= 1'b0;
        state_q <= IDLE;
        sda_o   <= 1'b1;
      end else begin
        case (state_q)
          ADDR: if (scl_rise) begin
            shift_q   <= {shift_q[DATA_WIDTH-2:0], sda_lvl};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            // On the R/W bit the previous seven samples hold the address.
            if (bit_cnt_q == LAST_BIT) begin
              if (shift_q[I2C_ADDR_WIDTH-1:0] == own_addr_i) begin
                dir_o     <= sda_lvl;
                ack_drv_q <= 1'b0;
                state_q   <= ADDR_ACK;
              end else begin
                state_q <= WAIT_STOP;
              end
            end
          end

          ADDR_ACK: if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_o     <= I2C_ACK;
              ack_drv_q <= 1'b1;
            end else if (dir_o) begin
              // The fall that ends the ACK also presents the first data bit.
              sda_o      <= tx_byte[DATA_WIDTH-1];
              shift_q    <= {tx_byte[DATA_WIDTH-2:0], 1'b1};
              bit_cnt_q  <= 4'd1;
              tx_ready_o <= 1'b1;
              state_q    <= TX_DATA;
            end else begin
              sda_o     <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= RX_DATA;
            end
          end

          RX_DATA: if (scl_rise) begin
            shift_q   <= {shift_q[DATA_WIDTH-2:0], sda_lvl};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_o  <= {shift_q[DATA_WIDTH-2:0], sda_lvl};
              rx_valid_o <= 1'b1;
              ack_drv_q  <= 1'b0;
              state_q    <= RX_ACK;
            end
          end

          RX_ACK: if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_o     <= I2C_ACK;
              ack_drv_q <= 1'b1;
            end else begin
              sda_o     <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= RX_DATA;
            end
          end

          TX_DATA: if (scl_fall) begin
            if (bit_cnt_q == '0) begin
              sda_o      <= tx_byte[DATA_WIDTH-1];
              shift_q    <= {tx_byte[DATA_WIDTH-2:0], 1'b1};
              bit_cnt_q  <= 4'd1;
              tx_ready_o <= 1'b1;
            end else if (bit_cnt_q == BYTE_DONE) begin
              sda_o   <= 1'b1;
              state_q <= TX_ACK;
            end else begin
              sda_o     <= shift_q[DATA_WIDTH-1];
              shift_q   <= {shift_q[DATA_WIDTH-2:0], 1'b1};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end

          TX_ACK: if (scl_rise) begin
            if (sda_lvl == I2C_ACK) begin
              bit_cnt_q <= '0;
              state_q   <= TX_DATA;
            end else begin
              state_q <= WAIT_STOP;
            end
          end

          default: ;
        endcase
      end

      if (!en_i) begin
        state_q <= IDLE;
        sda_o   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (slave) block that sits on the bus downstream of `i2c_master` and consumes the SCL/SDA it produces. It oversamples SCL/SDA in the system clock domain and detects START/STOP. It matches a 7-bit address, then either delivers received bytes to the fabric or serialises fabric-supplied bytes to the master. It is used as the bench/loopback counterpart of the master and as the on-chip register-port target.

## Interface
- `DATA_WIDTH`, 8, byte width; only 8 is supported.
- `FILTER_LEN`, 3, stable-sample count for the glitch filter (used only when the filter is compiled in).
- `clk_i`  in  1  system clock; all logic on rising edge.
- `a_rst_n_i`  in  1  reset; asynchronous, active-low.
- `en_i`  in  1  block enable; when low, the FSM is forced to IDLE and `sda_o` is 1.
- `own_addr_i`  in  7  target address; sampled at the address-match decision.
- `scl_i`  in  1  bus clock (asynchronous).
- `sda_i`  in  1  bus data (asynchronous).
- `sda_o`  out  1  open-drain data; 1 = release, 0 = pull low.
- `rx_data_o`  out  8  last received data byte, MSB first on the wire.
- `rx_valid_o`  out  1  one-cycle pulse when `rx_data_o` is updated.
- `tx_data_i`  in  8  byte to send in a read transfer.
- `tx_valid_i`  in  1  `tx_data_i` is valid.
- `tx_ready_o`  out  1  one-cycle pulse; byte taken when high together with `tx_valid_i`.
- `dir_o`  out  1  R/W bit of the current transfer; 1 = master reads.
- `start_o`  out  1  one-cycle pulse on START or repeated START.
- `stop_o`  out  1  one-cycle pulse on STOP.
- `busy_o`  out  1  high from START to STOP.

Reset values: `sda_o`=1, `rx_data_o`=0. All pulses and `dir_o`/`busy_o` are 0.

## Operation
- Line conditioning: `scl_i` and `sda_i` each pass through a 2-FF synchroniser, then edge detection. Edges are scl_rise, scl_fall, sda_rise and sda_fall.
- START: sda_fall while conditioned SCL is 1. STOP: sda_rise while SCL is 1. Either event takes priority over any FSM state.
  - START sets `busy_o` and goes to ADDR with the bit counter cleared.
  - STOP releases SDA, clears `busy_o` and goes to IDLE.
- Data is sampled on scl_rise. `sda_o` changes only on scl_fall.
- FSM states:
  - IDLE: waiting for START.
  - ADDR: shift 8 bits (7 address bits + R/W). On the 8th scl_rise, compare with `own_addr_i`. On a match, latch `dir_o` and go to ADDR_ACK. On a mismatch, go to WAIT_STOP.
  - ADDR_ACK: on scl_fall, drive 0. On the next scl_fall, release SDA. Next state is RX_DATA if `dir_o`=0, or TX_DATA after loading the shifter if `dir_o`=1.
  - RX_DATA: shift 8 bits. After the 8th bit, update `rx_data_o`, pulse `rx_valid_o` and go to RX_ACK.
  - RX_ACK: drive ACK (0) for one SCL period, as in ADDR_ACK, then go to RX_DATA. Every byte is ACKed; there is no back-pressure.
  - TX_DATA: present bit 7..0 on successive scl_fall. After the 8th bit, release SDA and go to TX_ACK.
  - TX_ACK: sample the master's bit on scl_rise. 0 (ACK) → reload the shifter and go to TX_DATA. 1 (NACK) → WAIT_STOP.
  - WAIT_STOP: SDA released; waiting for STOP or START.
- TX load: `tx_ready_o` pulses on the scl_fall that starts a byte.
  - If `tx_valid_i`=1, load `tx_data_i`.
  - Otherwise load 8'hFF. The bus then sees all-release.
- Repeated START in any state: pulse `start_o` and restart ADDR. `busy_o` stays high.
- `en_i` low mid-transfer: go to IDLE next cycle with SDA released. START/STOP pulses are still generated.
- `a_rst_n_i` asserted mid-transfer: all state returns to reset values immediately.

## Timing
- Bus-to-decision latency: 2 cycles for the synchroniser plus 1 cycle for edge detection. Add FILTER_LEN cycles when the filter is built in.
- `rx_valid_o` is asserted 1 cycle after the internal scl_rise of bit 0.
- `sda_o` changes 1 cycle after the internal scl_fall.
- Constraint: SCL low time ≥ 4 + FILTER_LEN `clk_i` periods. The master's prescale must honour this.
- START and STOP pulse 1 cycle after the sda edge is detected.

## Configuration
- `I2C_SLAVE_GLITCH_FILTER_EN` defined: each synchronised line feeds a filter. The filtered value updates only after FILTER_LEN consecutive identical samples, so pulses shorter than FILTER_LEN cycles are suppressed.
- Not defined: the synchroniser output is used directly, and `FILTER_LEN` is ignored.

## Structure
- `i2c_pkg`:
  - FSM state enum `i2c_slave_state_t` (IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP).
  - `I2C_ADDR_WIDTH` = 7.
  - `I2C_ACK` = 0 and `I2C_NACK` = 1.
- Sub-module `i2c_line_cond`: synchroniser, optional filter and rise/fall detection for one line. It is instantiated twice, once for SCL and once for SDA.

## Test plan
- Write 0x50 to address 0x2A, `own_addr_i`=0x2A:
  - `start_o` pulses.
  - ACK (0) is driven in the 9th clock.
  - `rx_valid_o` pulses with 0x50, followed by the data ACK.
  - `stop_o` pulses and `busy_o` falls.
- Address 0x2B with `own_addr_i`=0x2A: `sda_o` stays 1 throughout, no `rx_valid_o`, and the block returns to IDLE after STOP.
- Read from 0x2A with `tx_data_i`=0xA5 and `tx_valid_i`=1:
  - `tx_ready_o` pulses.
  - The wire carries 1010_0101.
  - Master NACK → WAIT_STOP, then STOP → IDLE.
- Read of 2 bytes, master ACKs then NACKs, second byte not valid: second byte reads 0xFF and `tx_ready_o` pulses twice.
- Repeated START after the write address ACK, then read: two `start_o` pulses, `dir_o` goes 0 → 1, and `busy_o` stays high.
- With `I2C_SLAVE_GLITCH_FILTER_EN`, inject a 1-cycle SDA low glitch while SCL is high: no `start_o`. Inject a (FILTER_LEN+1)-cycle low: `start_o` pulses. Assert `a_rst_n_i` mid-byte: all outputs return to reset values.
